// File: rtl/sevseg_pkg.sv
// Shared seven-segment definitions: active-low glyph table (bit0=a .. bit6=g),
// blank pattern and the scan-decoder FSM state type.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

endpackage

// File: rtl/sevseg_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
// Patterns outside the glyph table (blank included) report valid=0 and nibble=0.
module sevseg_glyph_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] segs,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (segs == GLYPHS[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Recovers the 32-bit word shown on a scanned 8-digit seven-segment display.
// Define SEVSEG_DEC_SYNC_EN to add 2-flop input synchronisers for asynchronous sources.
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  anode_select,
    input  logic [6:0]  segs,
    output logic [31:0] value,
    output logic [7:0]  err_mask,
    output logic        frame_valid
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [7:0] an;
    logic [6:0] sg;

`ifdef SEVSEG_DEC_SYNC_EN
    logic [7:0] an_p0, an_p1;
    logic [6:0] sg_p0, sg_p1;

    // Synchroniser stages reset to the idle (all lines off) level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_p0 <= '1;
            an_p1 <= '1;
            sg_p0 <= '1;
            sg_p1 <= '1;
        end else begin
            an_p0 <= anode_select;
            an_p1 <= an_p0;
            sg_p0 <= segs;
            sg_p1 <= sg_p0;
        end
    end

    assign an = an_p1;
    assign sg = sg_p1;
`else
    assign an = anode_select;
    assign sg = segs;
`endif

    logic [7:0]    an_prev;
    logic [6:0]    sg_prev;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    bitmap;
    logic [31:0]   shadow;
    logic [7:0]    shadow_err;

    logic          glyph_ok;
    logic [3:0]    nibble;

    sevseg_glyph_decode u_decode (
        .segs   (sg),
        .valid  (glyph_ok),
        .nibble (nibble)
    );

    logic [7:0]    an_low;
    logic          an_ok;
    logic          same;
    logic [2:0]    idx;
    logic [CW-1:0] cnt_nxt;
    logic          sample;
    logic [31:0]   shadow_new;
    logic [7:0]    err_new;
    logic [7:0]    bitmap_new;

    always_comb begin
        an_low = ~an;
        an_ok  = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        same   = (an == an_prev) && (sg == sg_prev);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        // The cycle that enters SETTLE already counts as the first stable cycle
        cnt_nxt = (state == SETTLE && same) ? cnt + 1'b1 : CW'(1);
        sample  = an_ok && !(state == CAPTURED && same) && (cnt_nxt == CW'(SETTLE_CYCLES));
        shadow_new = shadow;
        shadow_new[{idx, 2'b00} +: 4] = nibble;
        err_new      = shadow_err;
        err_new[idx] = !glyph_ok;
        bitmap_new   = bitmap | an_low;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_prev     <= '1;
            sg_prev     <= '1;
            state       <= IDLE;
            cnt         <= '0;
            bitmap      <= '0;
            shadow      <= '0;
            shadow_err  <= '0;
            value       <= '0;
            err_mask    <= '0;
            frame_valid <= 1'b0;
        end else begin
            an_prev     <= an;
            sg_prev     <= sg;
            frame_valid <= 1'b0;

            if (!an_ok) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (!(state == CAPTURED && same)) begin
                cnt   <= cnt_nxt;
                state <= sample ? CAPTURED : SETTLE;
            end

            if (sample) begin
                shadow     <= shadow_new;
                shadow_err <= err_new;
                // Publish straight from the merged shadow so the pulse lands the cycle after the 8th sample
                if (bitmap_new == 8'hFF) begin
                    value       <= shadow_new;
                    err_mask    <= err_new;
                    frame_valid <= 1'b1;
                    bitmap      <= '0;
                end else begin
                    bitmap <= bitmap_new;
                end
            end
        end
    end

endmodule
